// File: rtl/uart_rx_fifo_pkg.sv
// uart_pkg: definitions shared by the UART receive path.
//   PAR_NONE / PAR_ODD / PAR_EVEN : values for the PARITY parameter
//   rx_state_t                    : receiver FSM states
//   calc_div()                    : rounded system-clock cycles per oversample tick
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  // round(clk_hz / (baud * oversample)) in integer arithmetic
  function automatic int calc_div(input longint clk_hz, input longint baud,
                                  input longint oversample);
    longint den;
    den = baud * oversample;
    return int'((clk_hz + den / 2) / den);
  endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// sync_fifo: single-clock FIFO holding WIDTH-bit entries.
//   sys_clk, reset (async, active-low)
//   wr_en/wr_data : write request; accepted when not full, or when full and a
//                   read happens in the same cycle
//   rd_en         : read request; ignored when empty
//   rd_data       : head entry, driven to 0 while empty
//   full, empty, count : occupancy status
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                   sys_clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge sys_clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver feeding a small receive FIFO.
//   sys_clk, reset (async, active-low)
//   UART_RX        : asynchronous serial input, idles high
//   rx_data        : head-entry data (0 while empty)
//   rx_frame_err   : head-entry flag, a stop bit was sampled low
//   rx_parity_err  : head-entry flag, parity mismatch
//   rx_valid       : FIFO not empty
//   rx_ready       : consumer pops the head entry when rx_valid is high
//   rx_overrun     : one-cycle pulse, a frame was dropped because the FIFO was full
//   rx_count       : FIFO occupancy
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        sys_clk,
  input  logic                        reset,
  input  logic                        UART_RX,
  output logic [DATA_BITS-1:0]        rx_data,
  output logic                        rx_frame_err,
  output logic                        rx_parity_err,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic                        rx_overrun,
  output logic [$clog2(FIFO_DEPTH):0] rx_count
);

  localparam int DIV     = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SAMP_W  = $clog2(OVERSAMPLE);
  localparam int ENTRY_W = DATA_BITS + 2;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(OVERSAMPLE - 1);
  localparam logic [SAMP_W-1:0] SAMP_A    = SAMP_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SAMP_W-1:0] SAMP_B    = SAMP_W'(OVERSAMPLE / 2);
  localparam logic [SAMP_W-1:0] SAMP_C    = SAMP_W'(OVERSAMPLE / 2 + 1);
  localparam logic [3:0]        DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]        STOP_LAST = 4'(STOP_BITS - 1);

  logic                 rx_meta;
  logic                 rx_sync;
  logic [1:0]           sync_vld;
  logic                 rx_prev;
  logic                 start_det;
  logic [DIV_W-1:0]     div_cnt;
  logic                 tick;
  logic [SAMP_W-1:0]    samp_cnt;
  logic [SAMP_W-1:0]    samp_nxt;
  logic                 s_a;
  logic                 s_b;
  logic                 vote_tick;
  logic                 vote;
  rx_state_t            state;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] data_sr;
  logic                 par_err;
  logic                 frm_err;
  logic                 par_expected;
  logic                 push;
  logic [ENTRY_W-1:0]   push_entry;
  logic [ENTRY_W-1:0]   head;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;

  // rx_prev only counts as a real high once the synchroniser has flushed its
  // reset value, so a line that is low at reset release cannot fake a start edge.
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      sync_vld <= 2'b00;
      rx_prev  <= 1'b0;
    end else begin
      rx_meta  <= UART_RX;
      rx_sync  <= rx_meta;
      sync_vld <= {sync_vld[0], 1'b1};
      rx_prev  <= sync_vld[1] & rx_sync;
    end
  end

  assign start_det = (state == ST_IDLE) && rx_prev && !rx_sync;

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset)                               div_cnt <= '0;
    else if (start_det || div_cnt == DIV_LAST) div_cnt <= '0;
    else                                      div_cnt <= div_cnt + 1'b1;
  end

  assign tick = (div_cnt == DIV_LAST) && !start_det;

  // The counter value after tick k equals k, so tick k lands k*DIV cycles
  // after the start edge and the middle sample sits on the bit centre.
  assign samp_nxt  = (samp_cnt == SAMP_LAST) ? '0 : samp_cnt + 1'b1;
  assign vote_tick = tick && (samp_nxt == SAMP_C);
  assign vote      = (s_a & s_b) | (s_a & rx_sync) | (s_b & rx_sync);

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      samp_cnt <= '0;
      s_a      <= 1'b1;
      s_b      <= 1'b1;
    end else if (start_det) begin
      samp_cnt <= '0;
    end else if (tick) begin
      samp_cnt <= samp_nxt;
      if (samp_nxt == SAMP_A) s_a <= rx_sync;
      if (samp_nxt == SAMP_B) s_b <= rx_sync;
    end
  end

  assign par_expected = (PARITY == PAR_ODD) ? ~^data_sr : ^data_sr;

  // Frame FSM; every decision is taken on the third (voting) sample of a bit
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      data_sr <= '0;
      par_err <= 1'b0;
      frm_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_det) begin
            state   <= ST_START;
            bit_cnt <= '0;
            par_err <= 1'b0;
            frm_err <= 1'b0;
          end
        end
        ST_START: begin
          if (vote_tick) state <= vote ? ST_IDLE : ST_DATA;
        end
        ST_DATA: begin
          if (vote_tick) begin
            data_sr <= {vote, data_sr[DATA_BITS-1:1]};
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              state   <= (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (vote_tick) begin
            par_err <= (vote != par_expected);
            state   <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (vote_tick) begin
            if (bit_cnt == STOP_LAST) begin
              state <= ST_IDLE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              frm_err <= frm_err | ~vote;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The final stop vote is folded in directly so the push happens in that cycle
  assign push       = (state == ST_STOP) && vote_tick && (bit_cnt == STOP_LAST);
  assign push_entry = {data_sr, frm_err | ~vote, par_err};
  assign pop        = rx_valid && rx_ready;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .sys_clk (sys_clk),
    .reset   (reset),
    .wr_en   (push),
    .wr_data (push_entry),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (rx_count)
  );

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) rx_overrun <= 1'b0;
    else        rx_overrun <= push && fifo_full && !pop;
  end

  assign rx_valid = !fifo_empty;
  assign {rx_data, rx_frame_err, rx_parity_err} = head;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: checks two receiver configurations (no parity / 1 stop and
// even parity / 2 stop) against a frame-level queue model.
`timescale 1ns/1ps
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int  CLK_HZ = 100_000_000;
  localparam int  BAUD   = 3_125_000;
  localparam int  OS     = 16;
  localparam int  DEPTH  = 4;
  localparam real BIT_NS = 1.0e9 / BAUD;

  logic       clk = 1'b0;
  logic       reset;
  logic       line_a, line_b, ready_a, ready_b;
  logic [7:0] rx_data_a, rx_data_b;
  logic       rx_frame_err_a, rx_frame_err_b, rx_parity_err_a, rx_parity_err_b;
  logic       rx_valid_a, rx_valid_b, rx_overrun_a, rx_overrun_b;
  logic [2:0] rx_count_a, rx_count_b;

  int n_cmp  = 0;
  int n_fail = 0;
  int ovr_a = 0, ovr_b = 0, exp_ovr_a = 0, exp_ovr_b = 0;
  logic [9:0]  q_a[$];
  logic [9:0]  q_b[$];
  logic [31:0] exp_a_v, exp_b_v;

  always #5 clk = ~clk;

  uart_rx_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8),
                 .PARITY(PAR_NONE), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_a (
    .sys_clk(clk), .reset(reset), .UART_RX(line_a), .rx_data(rx_data_a),
    .rx_frame_err(rx_frame_err_a), .rx_parity_err(rx_parity_err_a),
    .rx_valid(rx_valid_a), .rx_ready(ready_a), .rx_overrun(rx_overrun_a),
    .rx_count(rx_count_a));

  uart_rx_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8),
                 .PARITY(PAR_EVEN), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) u_b (
    .sys_clk(clk), .reset(reset), .UART_RX(line_b), .rx_data(rx_data_b),
    .rx_frame_err(rx_frame_err_b), .rx_parity_err(rx_parity_err_b),
    .rx_valid(rx_valid_b), .rx_ready(ready_b), .rx_overrun(rx_overrun_b),
    .rx_count(rx_count_b));

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_line(input bit to_b, input logic v);
    if (to_b) line_b = v;
    else      line_a = v;
  endtask

  // The model holds what the FIFO should contain; a frame arriving when it
  // already holds DEPTH entries is dropped and counted as an overrun.
  task automatic model_push(input bit to_b, input logic [9:0] e);
    if (to_b) begin
      if (q_b.size() < DEPTH) q_b.push_back(e);
      else                    exp_ovr_b++;
    end else begin
      if (q_a.size() < DEPTH) q_a.push_back(e);
      else                    exp_ovr_a++;
    end
  endtask

  // One frame plus one idle bit; B carries an even-parity bit and two stops
  task automatic applyStimulus(input bit to_b, input logic [7:0] data, input bit par_ok,
                               input logic [1:0] stop_lvl, input real bit_ns);
    logic pbit, ferr, perr;
    pbit = (^data) ^ !par_ok;
    ferr = to_b ? !(stop_lvl[0] && stop_lvl[1]) : !stop_lvl[0];
    perr = to_b ? !par_ok : 1'b0;
    model_push(to_b, {data, ferr, perr});
    set_line(to_b, 1'b0);
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      set_line(to_b, data[i]);
      #(bit_ns);
    end
    if (to_b) begin
      set_line(to_b, pbit);
      #(bit_ns);
    end
    set_line(to_b, stop_lvl[0]);
    #(bit_ns);
    if (to_b) begin
      set_line(to_b, stop_lvl[1]);
      #(bit_ns);
    end
    set_line(to_b, 1'b1);
    #(bit_ns);
  endtask

  task automatic set_ready(input bit to_b, input logic v);
    @(posedge clk);
    #1;
    if (to_b) ready_b = v;
    else      ready_a = v;
  endtask

  task automatic drain(input bit to_b);
    set_ready(to_b, 1'b1);
    repeat (2 * DEPTH + 2) @(posedge clk);
    set_ready(to_b, 1'b0);
    @(negedge clk);
    if (to_b) begin
      checkOutput("b_drained_count", 32'(rx_count_b), 0);
      checkOutput("b_model_left", q_b.size(), 0);
      checkOutput("b_overruns", ovr_b, exp_ovr_b);
    end else begin
      checkOutput("a_drained_count", 32'(rx_count_a), 0);
      checkOutput("a_model_left", q_a.size(), 0);
      checkOutput("a_overruns", ovr_a, exp_ovr_a);
    end
  endtask

  // Every pop (valid && ready seen here, taken at the next rising edge) must
  // return the oldest model entry with its flags.
  always @(negedge clk) begin
    if (rx_valid_a && ready_a) begin
      if (q_a.size() > 0) exp_a_v = {22'd0, q_a.pop_front()};
      else                exp_a_v = 32'hBAD0_0000;
      checkOutput("a_pop_head", {22'd0, rx_data_a, rx_frame_err_a, rx_parity_err_a}, exp_a_v);
    end
    if (rx_valid_b && ready_b) begin
      if (q_b.size() > 0) exp_b_v = {22'd0, q_b.pop_front()};
      else                exp_b_v = 32'hBAD0_0000;
      checkOutput("b_pop_head", {22'd0, rx_data_b, rx_frame_err_b, rx_parity_err_b}, exp_b_v);
    end
    if (rx_overrun_a) ovr_a++;
    if (rx_overrun_b) ovr_b++;
  end

  initial begin
    int dur[7];
    int k;
    bit to_b;
    logic [7:0] d;
    bit pok;
    logic [1:0] sl;

    dur = '{3, 1, 4, 2, 4, 1, 3};
    reset = 1'b0; line_a = 1'b1; line_b = 1'b1; ready_a = 1'b0; ready_b = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("rst_a_valid", 32'(rx_valid_a), 0);
    checkOutput("rst_a_count", 32'(rx_count_a), 0);
    checkOutput("rst_a_data", 32'(rx_data_a), 0);
    checkOutput("rst_a_flags", {30'd0, rx_frame_err_a, rx_parity_err_a}, 0);
    checkOutput("rst_a_overrun", 32'(rx_overrun_a), 0);
    checkOutput("rst_a_state", 32'(u_a.state), 32'(ST_IDLE));
    checkOutput("rst_b_valid", 32'(rx_valid_b), 0);
    checkOutput("rst_b_count", 32'(rx_count_b), 0);
    reset = 1'b1;
    repeat (10) @(negedge clk);

    $display("[TB] back-to-back frames from level/duration waveform");
    model_push(0, {8'h84, 2'b00});
    model_push(0, {8'h88, 2'b00});
    for (int i = 0; i < 7; i++) begin
      set_line(0, (i % 2) == 1);
      #(BIT_NS * dur[i]);
    end
    set_line(0, 1'b1);
    #(BIT_NS * 2);
    @(negedge clk);
    checkOutput("b2b_count", 32'(rx_count_a), 2);
    checkOutput("b2b_valid", 32'(rx_valid_a), 1);
    drain(0);

    $display("[TB] glitch on idle line");
    set_line(0, 1'b0);
    #(BIT_NS * 0.3);
    set_line(0, 1'b1);
    #(BIT_NS * 2);
    @(negedge clk);
    checkOutput("glitch_count", 32'(rx_count_a), 0);
    checkOutput("glitch_state", 32'(u_a.state), 32'(ST_IDLE));
    applyStimulus(0, 8'h5B, 1, 2'b11, BIT_NS);
    drain(0);

    $display("[TB] parity and framing error");
    applyStimulus(1, 8'hA5, 0, 2'b10, BIT_NS);
    @(negedge clk);
    checkOutput("err_head_data", 32'(rx_data_b), 32'hA5);
    checkOutput("err_head_perr", 32'(rx_parity_err_b), 1);
    checkOutput("err_head_ferr", 32'(rx_frame_err_b), 1);
    drain(1);

    $display("[TB] overrun");
    for (int i = 1; i <= 5; i++) applyStimulus(0, 8'(i), 1, 2'b11, BIT_NS);
    @(negedge clk);
    checkOutput("ovr_count", 32'(rx_count_a), DEPTH);
    checkOutput("ovr_pulses", ovr_a, 1);
    drain(0);

    $display("[TB] reset during data bit 3");
    set_line(0, 1'b0);
    #(BIT_NS * 4.3);
    reset = 1'b0;
    q_a.delete();
    q_b.delete();
    #(BIT_NS * 0.2);
    reset = 1'b1;
    #(BIT_NS * 0.5);
    set_line(0, 1'b1);
    #(BIT_NS * 7);
    @(negedge clk);
    checkOutput("rstmid_no_entry", 32'(rx_count_a), 0);
    checkOutput("rstmid_state", 32'(u_a.state), 32'(ST_IDLE));
    applyStimulus(0, 8'h3C, 1, 2'b11, BIT_NS);
    @(negedge clk);
    checkOutput("rstmid_count", 32'(rx_count_a), 1);
    drain(0);

    $display("[TB] baud offset +/-3 percent");
    applyStimulus(0, 8'hC3, 1, 2'b11, BIT_NS * 1.03);
    applyStimulus(0, 8'hC3, 1, 2'b11, BIT_NS * 0.97);
    @(negedge clk);
    checkOutput("tol_count", 32'(rx_count_a), 2);
    drain(0);

    $display("[TB] ready held high");
    set_ready(0, 1'b1);
    applyStimulus(0, 8'h5A, 1, 2'b11, BIT_NS);
    applyStimulus(0, 8'hA5, 1, 2'b11, BIT_NS);
    @(negedge clk);
    checkOutput("rdyhigh_count", 32'(rx_count_a), 0);
    checkOutput("rdyhigh_model_left", q_a.size(), 0);
    set_ready(0, 1'b0);

    $display("[TB] random batches");
    for (int b = 0; b < 8; b++) begin
      to_b = (b % 2) == 1;
      k = $urandom_range(1, 5);
      for (int f = 0; f < k; f++) begin
        d   = 8'($urandom);
        pok = ($urandom_range(0, 3) != 0);
        sl  = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
        applyStimulus(to_b, d, pok, sl, BIT_NS);
      end
      @(negedge clk);
      if (to_b) checkOutput("rnd_b_count", 32'(rx_count_b), q_b.size());
      else      checkOutput("rnd_a_count", 32'(rx_count_a), q_a.size());
      drain(to_b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
